// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter that merges N_PORTS AXI-Stream requesters onto one UART tx stream.
// Whole packets are granted at a time; a grant is forcibly ended after MAX_BURST beats.
module uart_tx_arbiter #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_BURST  = 64
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [N_PORTS*DATA_WIDTH-1:0]                 s_tdata,
  input  logic [N_PORTS-1:0]                            s_tvalid,
  input  logic [N_PORTS-1:0]                            s_tlast,
  output logic [N_PORTS-1:0]                            s_tready,
  output logic [DATA_WIDTH-1:0]                         m_tdata,
  output logic                                          m_tvalid,
  output logic                                          m_tlast,
  input  logic                                          m_tready,
  output logic [((N_PORTS > 1) ? $clog2(N_PORTS) : 1)-1:0] m_tid,
  output logic                                          busy
);

  localparam int unsigned ID_W  = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned IDX_W = ID_W + 1;
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [ID_W-1:0]  grant, grant_nxt;
  logic [ID_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [CNT_W-1:0] beat_cnt, beat_cnt_nxt;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic [IDX_W-1:0] scan_idx;
  logic             burst_end;
  logic             beat;

  // Round-robin scan: first valid requester at or after rr_ptr, wrapping modulo N_PORTS.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      scan_idx = {1'b0, rr_ptr} + IDX_W'(k);
      if (scan_idx >= IDX_W'(N_PORTS)) begin
        scan_idx = scan_idx - IDX_W'(N_PORTS);
      end
      if (!found && s_tvalid[scan_idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = scan_idx[ID_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

  // Next state and pass-through outputs; outputs are forced quiet while reset is high.
  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    m_tdata      = '0;
    m_tvalid     = 1'b0;
    m_tlast      = 1'b0;
    m_tid        = '0;
    s_tready     = '0;
    busy         = 1'b0;
    burst_end    = 1'b0;
    beat         = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt    = winner;
          beat_cnt_nxt = '0;
          state_nxt    = GRANT;
        end
      end

      GRANT: begin
        burst_end = (beat_cnt == CNT_W'(MAX_BURST - 1));
        if (!reset) begin
          m_tdata         = s_tdata[DATA_WIDTH*32'(grant) +: DATA_WIDTH];
          m_tvalid        = s_tvalid[grant];
          m_tlast         = s_tlast[grant] | burst_end;
          m_tid           = grant;
          s_tready[grant] = m_tready;
          busy            = 1'b1;
        end
        beat = m_tvalid & m_tready;
        if (beat) begin
          if (m_tlast) begin
            state_nxt    = IDLE;
            rr_ptr_nxt   = (grant == ID_W'(N_PORTS - 1)) ? '0 : grant + 1'b1;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: queue-based requester sources, a packet-level
// arbitration model checked every cycle, and literal expected beat logs per scenario.
module tb_uart_tx_arbiter;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned MB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [1:0]        m_tid;
  logic              busy;

  uart_tx_arbiter #(
    .N_PORTS   (NP),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .s_tlast (s_tlast),
    .s_tready(s_tready),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tlast (m_tlast),
    .m_tready(m_tready),
    .m_tid   (m_tid),
    .busy    (busy)
  );

  int nchecks = 0;
  int nerr    = 0;
  int cyc     = 0;

  // Source queues: each entry is {last, data}.
  logic [8:0]    bq [NP][$];
  logic [NP-1:0] en;
  logic          rdy;

  // Packet-level model: who owns the stream, beats given in this grant, next priority.
  int owner = -1;
  int burst = 0;
  int ptr   = 0;

  logic          e_valid, e_last, e_busy;
  logic [DW-1:0] e_data;
  logic [1:0]    e_tid;
  logic [NP-1:0] e_tready;

  logic [15:0] logq[$];
  logic [15:0] expq[$];

  function automatic logic pres(int i);
    return en[i] && (bq[i].size() > 0);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] h;
    for (int i = 0; i < NP; i++) begin
      h = pres(i) ? bq[i][0] : 9'h000;
      s_tvalid[i]        = pres(i);
      s_tdata[i*DW +: DW] = h[7:0];
      s_tlast[i]         = h[8];
    end
    m_tready = rdy;
  endtask

  task automatic model_expect();
    logic [8:0] h;
    e_valid = 1'b0; e_last = 1'b0; e_busy = 1'b0;
    e_data = '0; e_tid = '0; e_tready = '0;
    if (!reset && owner >= 0) begin
      h        = pres(owner) ? bq[owner][0] : 9'h000;
      e_busy   = 1'b1;
      e_tid    = 2'(owner);
      e_valid  = pres(owner);
      e_data   = h[7:0];
      e_last   = h[8] || (burst == MB - 1);
      e_tready[owner] = rdy;
    end
  endtask

  task automatic model_update();
    if (reset) begin
      owner = -1; burst = 0; ptr = 0;
    end else if (owner < 0) begin
      for (int k = 0; k < NP; k++) begin
        if (owner < 0 && pres((ptr + k) % NP)) begin
          owner = (ptr + k) % NP;
          burst = 0;
        end
      end
    end else if (e_valid && rdy) begin
      if (e_last) begin
        ptr   = (owner + 1) % NP;
        owner = -1;
        burst = 0;
      end else begin
        burst++;
      end
    end
  endtask

  task automatic compare();
    chk($sformatf("cyc%0d m_tvalid", cyc), 32'(m_tvalid), 32'(e_valid));
    chk($sformatf("cyc%0d m_tlast", cyc),  32'(m_tlast),  32'(e_last));
    chk($sformatf("cyc%0d m_tdata", cyc),  32'(m_tdata),  32'(e_data));
    chk($sformatf("cyc%0d m_tid", cyc),    32'(m_tid),    32'(e_tid));
    chk($sformatf("cyc%0d busy", cyc),     32'(busy),     32'(e_busy));
    chk($sformatf("cyc%0d s_tready", cyc), 32'(s_tready), 32'(e_tready));
  endtask

  task automatic step();
    logic [NP-1:0] fire;
    drive();
    @(negedge clk);
    model_expect();
    compare();
    fire = s_tvalid & s_tready;
    if (m_tvalid && m_tready && !reset) begin
      logq.push_back({4'(m_tid), 3'b000, m_tlast, m_tdata});
    end
    @(posedge clk);
    model_update();
    for (int i = 0; i < NP; i++) begin
      if (fire[i]) void'(bq[i].pop_front());
    end
    #1;
    cyc++;
  endtask

  task automatic check_log(string nm);
    chk($sformatf("%s beat count", nm), 32'(logq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) begin
      chk($sformatf("%s beat %0d", nm, i),
          (i < logq.size()) ? 32'(logq[i]) : 32'hDEAD_BEEF, 32'(expq[i]));
    end
    logq.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < NP; i++) bq[i].delete();
    en    = '0;
    rdy   = 1'b1;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    logq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end by itself");
    $fatal(1);
  end

  initial begin
    logic [3:0] pat;
    reset = 1'b1;
    en    = '0;
    rdy   = 1'b1;
    drive();
    do_reset();

    // Idle after reset: nothing granted.
    repeat (20) step();
    expq.delete();
    check_log("idle");

    // Port 2 three-byte packet.
    bq[2] = '{9'h041, 9'h042, 9'h143};
    en[2] = 1'b1;
    repeat (8) step();
    expq = '{16'h2041, 16'h2042, 16'h2143};
    check_log("p2 packet");

    // rr_ptr now 3: port 3 beats port 0 when both request together.
    bq[0] = '{9'h101};
    bq[3] = '{9'h131};
    en    = 4'b1111;
    repeat (8) step();
    expq = '{16'h3131, 16'h0101};
    check_log("rr after p2");

    // Simultaneous requests from ports 0, 1, 3.
    do_reset();
    bq[0] = '{9'h0A0, 9'h1A1};
    bq[1] = '{9'h0B0, 9'h1B1};
    bq[3] = '{9'h0D0, 9'h1D1};
    en    = 4'b1011;
    repeat (14) step();
    expq = '{16'h00A0, 16'h01A1, 16'h10B0, 16'h11B1, 16'h30D0, 16'h31D1};
    check_log("three ports");

    // Forced release: port 1 streams ten bytes without tlast.
    do_reset();
    for (int b = 0; b < 10; b++) bq[1].push_back(9'(b));
    en[1] = 1'b1;
    repeat (20) step();
    expq = '{16'h1000, 16'h1001, 16'h1002, 16'h1103, 16'h1004,
             16'h1005, 16'h1006, 16'h1107, 16'h1008, 16'h1009};
    check_log("forced release");

    // Forced release with port 0 joining during the first burst.
    do_reset();
    for (int b = 0; b < 10; b++) bq[1].push_back(9'(b));
    bq[0] = '{9'h0C0, 9'h1C1};
    en[1] = 1'b1;
    repeat (2) step();
    en[0] = 1'b1;
    repeat (20) step();
    expq = '{16'h1000, 16'h1001, 16'h1002, 16'h1103, 16'h00C0, 16'h01C1,
             16'h1004, 16'h1005, 16'h1006, 16'h1107, 16'h1008, 16'h1009};
    check_log("release interleave");

    // Backpressure pattern 1,0,0,1 on port 0's packet.
    do_reset();
    bq[0] = '{9'h010, 9'h011, 9'h012, 9'h113};
    en[0] = 1'b1;
    pat   = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      rdy = pat[c % 4];
      step();
    end
    rdy = 1'b1;
    repeat (3) step();
    expq = '{16'h0010, 16'h0011, 16'h0012, 16'h0113};
    check_log("backpressure");

    // Reset after two beats of a five-byte packet on port 3.
    do_reset();
    bq[3] = '{9'h050, 9'h051, 9'h052, 9'h053, 9'h154};
    en[3] = 1'b1;
    for (int k = 0; k < 20 && logq.size() < 2; k++) step();
    chk("p3 two beats before reset", 32'(logq.size() >= 2), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (10) step();
    expq = '{16'h3050, 16'h3051, 16'h3052, 16'h3053, 16'h3154};
    check_log("reset mid packet");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit stream among N_PORTS independent AXI-Stream requesters, such as a command responder, a debug logger and a status reporter.
- Sits directly in front of the uart peripheral's tx_stream sink.
- Grants whole packets (ending at tlast) in round-robin order, so bytes from different requesters never interleave on the wire.
- Caps each grant at MAX_BURST beats so a requester that never asserts tlast cannot starve the others.

Parameters:
- N_PORTS, 4, number of requester streams (2..16)
- DATA_WIDTH, 8, tdata width of every stream
- MAX_BURST, 64, maximum beats per grant before forced release (>=1)

Ports:
- clk, input, 1, system clock; all logic on rising edge
- reset, input, 1, synchronous, active-high
- s_tdata, input, N_PORTS*DATA_WIDTH, requester data; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- s_tvalid, input, N_PORTS, per-requester valid
- s_tlast, input, N_PORTS, per-requester end of packet
- s_tready, output, N_PORTS, per-requester ready
- m_tdata, output, DATA_WIDTH, data to the UART tx_stream
- m_tvalid, output, 1, valid to the UART
- m_tlast, output, 1, end of packet; also asserted on a forced-release beat
- m_tready, input, 1, ready from the UART
- m_tid, output, max(1,$clog2(N_PORTS)), index of the granted requester
- busy, output, 1, high while in GRANT

Behaviour:
- Identifiers: ID_W = max(1,$clog2(N_PORTS)); CNT_W = $clog2(MAX_BURST+1).
- Registered state: state (IDLE/GRANT), grant (ID_W), rr_ptr (ID_W), beat_cnt (CNT_W).
- Reset values: state=IDLE, grant=0, rr_ptr=0, beat_cnt=0. All outputs 0 during reset and in IDLE: s_tready, m_tvalid, m_tlast, m_tdata, busy; m_tid=grant=0.
- IDLE:
  - Scan s_tvalid starting at index rr_ptr, wrapping modulo N_PORTS; the first set bit wins.
  - If any requester is valid, register grant=winner, beat_cnt=0, state→GRANT.
  - No data transfers in IDLE.
- GRANT (combinational pass-through from granted port g):
  - m_tdata=s_tdata[g], m_tvalid=s_tvalid[g], s_tready[g]=m_tready; all other s_tready=0.
  - m_tlast = s_tlast[g] OR (beat_cnt==MAX_BURST-1).
  - m_tid=g, busy=1.
- Beat = m_tvalid && m_tready in GRANT. On each beat:
  - If m_tlast: state→IDLE, rr_ptr=(g+1) mod N_PORTS, beat_cnt=0.
  - Otherwise: beat_cnt+1.
- Latency: one cycle from a requester's tvalid (seen in IDLE) to its first beat being presentable. There is exactly one idle cycle between consecutive grants.
- Granted requester deasserting tvalid mid-packet: grant holds and no beat occurs. No timeout.
- Non-granted requesters: s_tready stays 0 and their tvalid/tdata are ignored. AXIS rules require them to hold tvalid.
- Simultaneous requests: round-robin from rr_ptr. After serving port k, port k is lowest priority for the next decision.
- A single requester repeatedly sends packets: served every other cycle boundary (IDLE cycle between packets). Not starved; not blocked.
- rr_ptr wrap: index N_PORTS-1 wraps to 0. For a non-power-of-2 N_PORTS, the computed index never reaches an unused value.
- Forced release: after MAX_BURST beats without tlast, the arbiter emits m_tlast on beat MAX_BURST and releases the grant. The requester's remaining bytes resume at its next grant.
- Reset mid-packet: on the next clock edge all state returns to reset values and s_tready/m_tvalid drop immediately. The partial packet is abandoned with no m_tlast emitted.
- m_tready low: no state change. Outputs follow the granted inputs; the AXIS stability requirement transfers from the requester.

Test Plan:
- Reset, then idle: all s_tvalid=0 for 20 cycles → m_tvalid=0, busy=0, s_tready=0, m_tid=0.
- Port 2 sends a 3-byte packet 0x41,0x42,0x43 (tlast on 0x43) with m_tready=1 → 1 cycle after s_tvalid[2], output shows 0x41,0x42,0x43 on 3 consecutive cycles, m_tid=2, m_tlast only on 0x43, then busy=0 and rr_ptr=3.
- Ports 0,1,3 each hold a 2-byte packet valid simultaneously from reset → packets output in order 0,1,3, never interleaved, one idle cycle between packets, each m_tlast aligned with its source tlast.
- MAX_BURST=4, port 1 streams 10 bytes 0x00..0x09 with no tlast and port 0 idle → bytes 0x00..0x03 with m_tlast on 0x03, IDLE cycle, 0x04..0x07 with m_tlast, IDLE, then 0x08,0x09 pending. With port 0 requesting after the first burst, port 0's packet is output between 0x03 and 0x04.
- Backpressure: m_tready toggles 1,0,0,1 during port 0's 4-byte packet → no byte lost or duplicated; s_tready[0] mirrors m_tready; beat_cnt advances only on beats.
- Reset asserted for 1 cycle after the 2nd byte of a 5-byte packet on port 3 → next cycle m_tvalid=0, s_tready=0, busy=0, rr_ptr=0. After reset, port 3 (still valid) is re-granted and its stream resumes from its current byte.
